// File: rtl/demux5_reg.sv
// Routes each input beat to one of five single-entry register slots; 1-cycle latency, 1 beat/cycle per lane.
// in_ready drops only when the chosen slot is full and not popping; illegal selects are always taken and counted.
module demux5_reg #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [2:0]     in_sel,
  output logic [4:0]     out_valid,
  input  logic [4:0]     out_ready,
  output logic [5*W-1:0] out_data,
  input  logic           drop_clr,
  output logic [7:0]     drop_cnt
);

  logic [4:0]   full;
  logic [W-1:0] data [5];
  logic [4:0]   lane_rdy;
  logic [4:0]   acc;
  logic         sel_legal;
  logic         drop_acc;

  assign sel_legal = (in_sel < 3'd5);
  assign lane_rdy  = ~full | out_ready;
  assign drop_acc  = in_valid && !sel_legal;

  always_comb begin
    in_ready = 1'b1;
    acc      = '0;
    for (int k = 0; k < 5; k++) begin
      if (in_sel == 3'(k)) begin
        in_ready = lane_rdy[k];
        acc[k]   = in_valid && lane_rdy[k];
      end
    end
  end

  // An accept wins over a same-cycle pop, keeping the slot full at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int k = 0; k < 5; k++) data[k] <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (acc[k]) begin
          full[k] <= 1'b1;
          data[k] <= in_data;
        end else if (full[k] && out_ready[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= drop_acc ? 8'd1 : 8'd0;
    end else if (drop_acc && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign out_valid = full;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 5; k++) out_data[k*W +: W] = data[k];
  end

endmodule
